bellek_hakemi: RTL and testbench
================================

# bellek_hakemi

Arbiter that shares one memory/L1 request port between the instruction fetch stage (ib, the getir1 request side) and the data memory stage (vb). It tracks every in-flight request in an in-order tag FIFO so that each response goes back to the requester that issued it. It also silently drains instruction responses made stale by a fetch redirect. It sits between getir1/bellek stages and the shared L1 port.

## Interface
- MAX_BEKLEYEN, 4: max in-flight memory requests; power of two, ≥2
- ACLIK_SINIRI, 3: consecutive vb grants allowed while ib waits (fixed-priority mode)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- ib_istek_adres_i  in  32  fetch address
- ib_istek_gecerli_i / ib_istek_hazir_o  in/out  1  fetch request handshake
- ib_yanit_veri_o  out  32  fetch response data
- ib_yanit_gecerli_o / ib_yanit_hazir_i  out/in  1  fetch response handshake
- ib_iptal_i  in  1  redirect pulse: drop all in-flight fetch responses
- vb_istek_adres_i, vb_istek_veri_i  in  32  data address / write data
- vb_istek_yaz_i  in  1  1 = write
- vb_istek_maske_i  in  4  byte enables
- vb_istek_gecerli_i / vb_istek_hazir_o  in/out  1  data request handshake
- vb_yanit_veri_o  out  32  load data
- vb_yanit_gecerli_o / vb_yanit_hazir_i  out/in  1  load response handshake
- bel_istek_adres_o, bel_istek_veri_o  out  32; bel_istek_yaz_o out 1; bel_istek_maske_o out 4  muxed request; ib side drives yaz=0, maske=4'hF, veri=0
- bel_istek_gecerli_o / bel_istek_hazir_i  out/in  1  memory request handshake
- bel_yanit_veri_i  in  32; bel_yanit_gecerli_i / bel_yanit_hazir_o  in/out  1  memory response, strictly in request order

## Operation
- Request path combinational. A transfer happens when bel_istek_gecerli_o & bel_istek_hazir_i. Winner's *_istek_hazir_o = bel_istek_hazir_i; loser's = 0.
- FIFO full (MAX_BEKLEYEN entries): bel_istek_gecerli_o=0, both istek_hazir_o=0. Push is blocked when full even if a pop happens the same cycle.
- FSM SECIM (choose): winner computed from the current valids. SECIM→KILIT when bel_istek_gecerli_o=1 & bel_istek_hazir_i=0. In KILIT the grant is frozen and the request is held stable until accepted. Acceptance returns the FSM to SECIM.
- Fixed-priority choice: vb wins over ib. The aclik counter increments on each vb grant while ib_istek_gecerli_i=1 and clears on any ib grant. When aclik==ACLIK_SINIRI, ib wins.
- Each accepted request pushes tag {kaynak(0=ib,1=vb), yaz, dusur=0}.
- Response routing uses the FIFO head:
  - Head is a vb write, or has dusur=1: bel_yanit_hazir_o=1 and the response is consumed silently.
  - Head is ib: ib_yanit_gecerli_o=bel_yanit_gecerli_i & ~ib_iptal_i, and bel_yanit_hazir_o=ib_yanit_hazir_i | ib_iptal_i.
  - Head is a vb read: forwarded to vb.
  - A response with the FIFO empty is a protocol error and is ignored (hazir_o=0).
- ib_iptal_i marks dusur=1 on every ib entry in the FIFO at that edge. An ib request accepted in the same cycle is not marked.
- Response data outputs mirror bel_yanit_veri_i.

## Timing
- Request path: 0 cycles. Response path: 0 cycles. Tag push/pop take effect at the next edge.
- Reset values:
  - FSM=SECIM, FIFO empty, aclik=0.
  - All *_gecerli_o = 0; all *_hazir_o = 0.
  - All data/address/mask outputs = 0.
- Simultaneous push+pop (not full): occupancy unchanged.
- Reset mid-transaction discards all tags. Memory-side state must be reset together with this block.
- Pointer arithmetic: log2(MAX_BEKLEYEN)-bit pointers wrapping mod depth, plus a separate occupancy counter of log2(MAX_BEKLEYEN)+1 bits.

## Configuration
- BELLEK_HAKEMI_RR_EN defined: round-robin in SECIM. The last winner gets lowest priority next time; aclik counter and ACLIK_SINIRI are unused.
- Undefined: fixed vb priority with the ACLIK_SINIRI anti-starvation rule.

## Test plan
- ib only, bel_istek_hazir_i=1, addresses 0x4000_0000+4k for k=0..7, memory responds next cycle with data=address → ib receives 8 responses in order with data 0x4000_0000..0x4000_001C; no cycle lost.
- Both valid every cycle, default build, ACLIK_SINIRI=3 → grant pattern vb,vb,vb,ib repeating.
  - With BELLEK_HAKEMI_RR_EN: vb,ib alternating.
- Memory stalls: bel_istek_hazir_i=0 for 5 cycles while ib is valid, then vb becomes valid → the ib request stays granted (KILIT), with address stable, until accepted.
- No memory responses; issue 4 requests → fifth request blocked (both istek_hazir_o=0). One response → exactly one more request accepted.
- 3 ib reads in flight, ib_iptal_i pulse, then new ib read 0x4000_0100 → first 3 responses consumed with ib_yanit_gecerli_o=0; 4th delivered.
- vb write followed by vb read 0x10 → write response swallowed (vb_yanit_gecerli_o=0); read data delivered. Assert rst_i mid-sequence → all outputs 0 immediately.

Source files
------------

// File: rtl/bellek_hakemi.sv
// rtl/bellek_hakemi.sv - ib/vb arbiter for one shared L1 port with in-order response tag FIFO
// Optional feature: define BELLEK_HAKEMI_RR_EN for round-robin choice instead of fixed vb priority.
module bellek_hakemi #(
  parameter int MAX_BEKLEYEN = 4,
  parameter int ACLIK_SINIRI = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ib_istek_adres_i,
  input  logic        ib_istek_gecerli_i,
  output logic        ib_istek_hazir_o,
  output logic [31:0] ib_yanit_veri_o,
  output logic        ib_yanit_gecerli_o,
  input  logic        ib_yanit_hazir_i,
  input  logic        ib_iptal_i,
  input  logic [31:0] vb_istek_adres_i,
  input  logic [31:0] vb_istek_veri_i,
  input  logic        vb_istek_yaz_i,
  input  logic [3:0]  vb_istek_maske_i,
  input  logic        vb_istek_gecerli_i,
  output logic        vb_istek_hazir_o,
  output logic [31:0] vb_yanit_veri_o,
  output logic        vb_yanit_gecerli_o,
  input  logic        vb_yanit_hazir_i,
  output logic [31:0] bel_istek_adres_o,
  output logic [31:0] bel_istek_veri_o,
  output logic        bel_istek_yaz_o,
  output logic [3:0]  bel_istek_maske_o,
  output logic        bel_istek_gecerli_o,
  input  logic        bel_istek_hazir_i,
  input  logic [31:0] bel_yanit_veri_i,
  input  logic        bel_yanit_gecerli_i,
  output logic        bel_yanit_hazir_o
);

  localparam int PW = $clog2(MAX_BEKLEYEN);
  localparam logic [PW:0] DERINLIK = MAX_BEKLEYEN[PW:0];
  localparam logic KAYNAK_IB = 1'b0;
  localparam logic KAYNAK_VB = 1'b1;

  typedef enum logic {SECIM, KILIT} durum_t;

  durum_t        durum;
  logic          kilit_kaynak;
  logic          kaynak_q [MAX_BEKLEYEN];
  logic          yaz_q    [MAX_BEKLEYEN];
  logic          dusur_q  [MAX_BEKLEYEN];
  logic [PW-1:0] yaz_ptr;
  logic [PW-1:0] oku_ptr;
  logic [PW:0]   doluluk;

  logic dolu, bos, secim, kazanan, istek_var, kabul;
  logic bas_kaynak, bas_yaz, bas_dusur, sessiz;
  logic yanit_hazir, ib_gecerli, vb_gecerli, cek;

`ifdef BELLEK_HAKEMI_RR_EN
  logic son_kazanan;

  always_comb begin
    if (ib_istek_gecerli_i && vb_istek_gecerli_i) secim = ~son_kazanan;
    else if (ib_istek_gecerli_i)                  secim = KAYNAK_IB;
    else                                          secim = KAYNAK_VB;
  end
`else
  localparam int AW = $clog2(ACLIK_SINIRI + 1);
  localparam logic [AW-1:0] SINIR = AW'(ACLIK_SINIRI);
  logic [AW-1:0] aclik;

  // vb has priority until ib has watched SINIR consecutive vb grants
  always_comb begin
    if (ib_istek_gecerli_i && vb_istek_gecerli_i) secim = (aclik == SINIR) ? KAYNAK_IB : KAYNAK_VB;
    else if (ib_istek_gecerli_i)                  secim = KAYNAK_IB;
    else                                          secim = KAYNAK_VB;
  end
`endif

  assign dolu      = (doluluk == DERINLIK);
  assign bos       = (doluluk == '0);
  assign kazanan   = (durum == KILIT) ? kilit_kaynak : secim;
  assign istek_var = ~dolu & (kazanan ? vb_istek_gecerli_i : ib_istek_gecerli_i);
  assign kabul     = istek_var & bel_istek_hazir_i;

  assign bel_istek_gecerli_o = ~rst_i & istek_var;
  assign ib_istek_hazir_o    = ~rst_i & ~dolu & ~kazanan & bel_istek_hazir_i;
  assign vb_istek_hazir_o    = ~rst_i & ~dolu & kazanan & bel_istek_hazir_i;
  assign bel_istek_adres_o   = rst_i ? '0 : (kazanan ? vb_istek_adres_i : ib_istek_adres_i);
  assign bel_istek_veri_o    = (rst_i | ~kazanan) ? '0 : vb_istek_veri_i;
  assign bel_istek_yaz_o     = ~rst_i & kazanan & vb_istek_yaz_i;
  assign bel_istek_maske_o   = rst_i ? 4'h0 : (kazanan ? vb_istek_maske_i : 4'hF);

  assign bas_kaynak = kaynak_q[oku_ptr];
  assign bas_yaz    = yaz_q[oku_ptr];
  assign bas_dusur  = dusur_q[oku_ptr];
  assign sessiz     = bas_dusur | (bas_kaynak & bas_yaz);

  always_comb begin
    yanit_hazir = 1'b0;
    ib_gecerli  = 1'b0;
    vb_gecerli  = 1'b0;
    if (!bos && !rst_i) begin
      if (sessiz) begin
        yanit_hazir = 1'b1;
      end else if (bas_kaynak == KAYNAK_IB) begin
        ib_gecerli  = bel_yanit_gecerli_i & ~ib_iptal_i;
        yanit_hazir = ib_yanit_hazir_i | ib_iptal_i;
      end else begin
        vb_gecerli  = bel_yanit_gecerli_i;
        yanit_hazir = vb_yanit_hazir_i;
      end
    end
  end

  assign cek                = bel_yanit_gecerli_i & yanit_hazir;
  assign bel_yanit_hazir_o  = yanit_hazir;
  assign ib_yanit_gecerli_o = ib_gecerli;
  assign vb_yanit_gecerli_o = vb_gecerli;
  assign ib_yanit_veri_o    = rst_i ? '0 : bel_yanit_veri_i;
  assign vb_yanit_veri_o    = rst_i ? '0 : bel_yanit_veri_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum        <= SECIM;
      kilit_kaynak <= KAYNAK_IB;
      yaz_ptr      <= '0;
      oku_ptr      <= '0;
      doluluk      <= '0;
      for (int i = 0; i < MAX_BEKLEYEN; i++) begin
        kaynak_q[i] <= 1'b0;
        yaz_q[i]    <= 1'b0;
        dusur_q[i]  <= 1'b0;
      end
`ifdef BELLEK_HAKEMI_RR_EN
      son_kazanan <= KAYNAK_IB;
`else
      aclik <= '0;
`endif
    end else begin
      case (durum)
        SECIM: if (istek_var && !bel_istek_hazir_i) begin
          durum        <= KILIT;
          kilit_kaynak <= kazanan;
        end
        KILIT: if (kabul) durum <= SECIM;
        default: durum <= SECIM;
      endcase

      // redirect marks older ib entries; a same-cycle push below overrides its own slot
      for (int i = 0; i < MAX_BEKLEYEN; i++)
        if (ib_iptal_i && kaynak_q[i] == KAYNAK_IB) dusur_q[i] <= 1'b1;

      if (kabul) begin
        kaynak_q[yaz_ptr] <= kazanan;
        yaz_q[yaz_ptr]    <= kazanan & vb_istek_yaz_i;
        dusur_q[yaz_ptr]  <= 1'b0;
        yaz_ptr           <= yaz_ptr + 1'b1;
      end
      if (cek) oku_ptr <= oku_ptr + 1'b1;

      case ({kabul, cek})
        2'b10:   doluluk <= doluluk + 1'b1;
        2'b01:   doluluk <= doluluk - 1'b1;
        default: doluluk <= doluluk;
      endcase

`ifdef BELLEK_HAKEMI_RR_EN
      if (kabul) son_kazanan <= kazanan;
`else
      if (kabul) begin
        if (kazanan == KAYNAK_IB)                     aclik <= '0;
        else if (ib_istek_gecerli_i && aclik != SINIR) aclik <= aclik + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bellek_hakemi.sv
// tb/tb_bellek_hakemi.sv - randomized and directed checks of bellek_hakemi against a tag-queue model
`timescale 1ns/1ps
module tb_bellek_hakemi;

  localparam int DERIN = 4;
  localparam int SINIR = 3;
  localparam logic [31:0] ANAHTAR = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ib_istek_adres_i;
  logic        ib_istek_gecerli_i, ib_istek_hazir_o;
  logic [31:0] ib_yanit_veri_o;
  logic        ib_yanit_gecerli_o, ib_yanit_hazir_i, ib_iptal_i;
  logic [31:0] vb_istek_adres_i, vb_istek_veri_i;
  logic        vb_istek_yaz_i;
  logic [3:0]  vb_istek_maske_i;
  logic        vb_istek_gecerli_i, vb_istek_hazir_o;
  logic [31:0] vb_yanit_veri_o;
  logic        vb_yanit_gecerli_o, vb_yanit_hazir_i;
  logic [31:0] bel_istek_adres_o, bel_istek_veri_o;
  logic        bel_istek_yaz_o;
  logic [3:0]  bel_istek_maske_o;
  logic        bel_istek_gecerli_o, bel_istek_hazir_i;
  logic [31:0] bel_yanit_veri_i;
  logic        bel_yanit_gecerli_i, bel_yanit_hazir_o;

  always #5 clk = ~clk;

  bellek_hakemi #(.MAX_BEKLEYEN(DERIN), .ACLIK_SINIRI(SINIR)) dut (
    .clk_i(clk), .rst_i(rst),
    .ib_istek_adres_i(ib_istek_adres_i), .ib_istek_gecerli_i(ib_istek_gecerli_i),
    .ib_istek_hazir_o(ib_istek_hazir_o), .ib_yanit_veri_o(ib_yanit_veri_o),
    .ib_yanit_gecerli_o(ib_yanit_gecerli_o), .ib_yanit_hazir_i(ib_yanit_hazir_i),
    .ib_iptal_i(ib_iptal_i),
    .vb_istek_adres_i(vb_istek_adres_i), .vb_istek_veri_i(vb_istek_veri_i),
    .vb_istek_yaz_i(vb_istek_yaz_i), .vb_istek_maske_i(vb_istek_maske_i),
    .vb_istek_gecerli_i(vb_istek_gecerli_i), .vb_istek_hazir_o(vb_istek_hazir_o),
    .vb_yanit_veri_o(vb_yanit_veri_o), .vb_yanit_gecerli_o(vb_yanit_gecerli_o),
    .vb_yanit_hazir_i(vb_yanit_hazir_i),
    .bel_istek_adres_o(bel_istek_adres_o), .bel_istek_veri_o(bel_istek_veri_o),
    .bel_istek_yaz_o(bel_istek_yaz_o), .bel_istek_maske_o(bel_istek_maske_o),
    .bel_istek_gecerli_o(bel_istek_gecerli_o), .bel_istek_hazir_i(bel_istek_hazir_i),
    .bel_yanit_veri_i(bel_yanit_veri_i), .bel_yanit_gecerli_i(bel_yanit_gecerli_i),
    .bel_yanit_hazir_o(bel_yanit_hazir_o)
  );

  typedef struct packed {
    logic        vb;
    logic        yaz;
    logic        dusur;
    logic [31:0] veri;
  } etiket_t;

  etiket_t     etiketler[$];
  logic [31:0] bellek_q[$];
  int kilitli, aclik_m, son_m;
  bit ib_kabul, vb_kabul;
  int ib_kabul_say;
  int tests = 0;
  int fails = 0;

  task automatic kontrol(input string ad, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    tests++;
    if (gozlenen !== beklenen) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", ad, gozlenen, beklenen, $time);
    end
  endtask

  function automatic bit sans(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic model_sifirla();
    etiketler.delete();
    bellek_q.delete();
    kilitli = -1; aclik_m = 0; son_m = 0;
    ib_kabul = 0; vb_kabul = 0;
  endtask

  task automatic sifir_kontrol(input string ad);
    kontrol({ad, "_adres"}, bel_istek_adres_o, 0);
    kontrol({ad, "_veri"}, bel_istek_veri_o, 0);
    kontrol({ad, "_ib_veri"}, ib_yanit_veri_o, 0);
    kontrol({ad, "_vb_veri"}, vb_yanit_veri_o, 0);
    kontrol({ad, "_bayrak"}, 32'({bel_istek_gecerli_o, bel_istek_yaz_o, bel_istek_maske_o,
            ib_istek_hazir_o, vb_istek_hazir_o, ib_yanit_gecerli_o, vb_yanit_gecerli_o,
            bel_yanit_hazir_o}), 0);
  endtask

  task automatic sur(input int ib_p, input int vb_p, input int hz_p,
                     input int gv_p, input int yh_p, input int ip_p);
    if (ib_kabul) ib_istek_gecerli_i = 1'b0;
    if (vb_kabul) vb_istek_gecerli_i = 1'b0;
    ib_kabul = 0; vb_kabul = 0;
    if (!ib_istek_gecerli_i && sans(ib_p)) begin
      ib_istek_gecerli_i = 1'b1;
      ib_istek_adres_i   = $urandom & ~32'h3;
    end
    if (!vb_istek_gecerli_i && sans(vb_p)) begin
      vb_istek_gecerli_i = 1'b1;
      vb_istek_adres_i   = $urandom;
      vb_istek_veri_i    = $urandom;
      vb_istek_yaz_i     = sans(50);
      vb_istek_maske_i   = 4'($urandom);
    end
    bel_istek_hazir_i   = sans(hz_p);
    bel_yanit_gecerli_i = (bellek_q.size() > 0) && sans(gv_p);
    bel_yanit_veri_i    = (bellek_q.size() > 0) ? (bellek_q[0] ^ ANAHTAR) : $urandom;
    ib_yanit_hazir_i    = sans(yh_p);
    vb_yanit_hazir_i    = sans(yh_p);
    ib_iptal_i          = sans(ip_p);
  endtask

  // Reference: compute expected outputs from the arbitration/routing rules, then advance the model
  task automatic adim();
    int kazanan;
    bit dolu, gecerli, kabul, hazir, ib_gv, vb_gv, cek;
    etiket_t bas, yeni;
    if (kilitli >= 0) kazanan = kilitli;
    else if (ib_istek_gecerli_i && vb_istek_gecerli_i) begin
`ifdef BELLEK_HAKEMI_RR_EN
      kazanan = (son_m == 1) ? 0 : 1;
`else
      kazanan = (aclik_m == SINIR) ? 0 : 1;
`endif
    end else kazanan = ib_istek_gecerli_i ? 0 : 1;
    dolu    = etiketler.size() == DERIN;
    gecerli = !dolu && (kazanan == 1 ? vb_istek_gecerli_i : ib_istek_gecerli_i);
    kabul   = gecerli && bel_istek_hazir_i;
    kontrol("istek_gecerli", 32'(bel_istek_gecerli_o), 32'(gecerli));
    kontrol("ib_istek_hazir", 32'(ib_istek_hazir_o), 32'(!dolu && kazanan == 0 && bel_istek_hazir_i));
    kontrol("vb_istek_hazir", 32'(vb_istek_hazir_o), 32'(!dolu && kazanan == 1 && bel_istek_hazir_i));
    if (gecerli) begin
      kontrol("istek_adres", bel_istek_adres_o, kazanan == 1 ? vb_istek_adres_i : ib_istek_adres_i);
      kontrol("istek_veri", bel_istek_veri_o, kazanan == 1 ? vb_istek_veri_i : 32'h0);
      kontrol("istek_kontrol", 32'({bel_istek_yaz_o, bel_istek_maske_o}),
              kazanan == 1 ? 32'({vb_istek_yaz_i, vb_istek_maske_i}) : 32'h0F);
    end

    hazir = 0; ib_gv = 0; vb_gv = 0; bas = '0;
    if (etiketler.size() > 0) begin
      bas = etiketler[0];
      if (bas.dusur || (bas.vb && bas.yaz)) hazir = 1;
      else if (!bas.vb) begin
        ib_gv = bel_yanit_gecerli_i && !ib_iptal_i;
        hazir = ib_yanit_hazir_i || ib_iptal_i;
      end else begin
        vb_gv = bel_yanit_gecerli_i;
        hazir = vb_yanit_hazir_i;
      end
    end
    kontrol("yanit_hazir", 32'(bel_yanit_hazir_o), 32'(hazir));
    kontrol("ib_yanit_gecerli", 32'(ib_yanit_gecerli_o), 32'(ib_gv));
    kontrol("vb_yanit_gecerli", 32'(vb_yanit_gecerli_o), 32'(vb_gv));
    cek = bel_yanit_gecerli_i && hazir;
    if (cek && ib_gv && ib_yanit_hazir_i) kontrol("ib_veri", ib_yanit_veri_o, bas.veri);
    if (cek && vb_gv && vb_yanit_hazir_i) kontrol("vb_veri", vb_yanit_veri_o, bas.veri);

    if (cek) void'(etiketler.pop_front());
    if (ib_iptal_i)
      foreach (etiketler[i]) begin
        yeni = etiketler[i];
        if (!yeni.vb) yeni.dusur = 1'b1;
        etiketler[i] = yeni;
      end
    if (kabul) begin
      yeni.vb    = (kazanan == 1);
      yeni.yaz   = (kazanan == 1) && vb_istek_yaz_i;
      yeni.dusur = 1'b0;
      yeni.veri  = (kazanan == 1 ? vb_istek_adres_i : ib_istek_adres_i) ^ ANAHTAR;
      etiketler.push_back(yeni);
      kilitli = -1;
      son_m = kazanan;
      if (kazanan == 0) aclik_m = 0;
      else if (ib_istek_gecerli_i && aclik_m < SINIR) aclik_m++;
    end else if (gecerli) kilitli = kazanan;

    if (bel_yanit_gecerli_i && bel_yanit_hazir_o && bellek_q.size() > 0) void'(bellek_q.pop_front());
    if (bel_istek_gecerli_o && bel_istek_hazir_i) bellek_q.push_back(bel_istek_adres_o);
    if (ib_istek_gecerli_i && ib_istek_hazir_o) begin ib_kabul = 1; ib_kabul_say++; end
    if (vb_istek_gecerli_i && vb_istek_hazir_o) vb_kabul = 1;
  endtask

  task automatic dongu(input int ib_p, input int vb_p, input int hz_p,
                       input int gv_p, input int yh_p, input int ip_p);
    sur(ib_p, vb_p, hz_p, gv_p, yh_p, ip_p);
    #3;
    adim();
    @(posedge clk); #1;
  endtask

  initial begin
    model_sifirla();
    ib_kabul_say = 0;
    rst = 1'b1;
    ib_istek_gecerli_i = 1'b1; ib_istek_adres_i = 32'h4000_0000;
    vb_istek_gecerli_i = 1'b1; vb_istek_adres_i = 32'h0000_0010; vb_istek_veri_i = 32'h1111_2222;
    vb_istek_yaz_i = 1'b1; vb_istek_maske_i = 4'h3;
    bel_istek_hazir_i = 1'b1; bel_yanit_gecerli_i = 1'b1; bel_yanit_veri_i = 32'hDEAD_BEEF;
    ib_yanit_hazir_i = 1'b1; vb_yanit_hazir_i = 1'b1; ib_iptal_i = 1'b0;
    #3;
    sifir_kontrol("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    vb_istek_yaz_i = 1'b0;

    // both requesters always valid, everything ready
    for (int k = 0; k < 8; k++) begin
      sur(100, 100, 100, 100, 100, 0);
      #3;
`ifdef BELLEK_HAKEMI_RR_EN
      kontrol("desen", 32'(vb_istek_hazir_o), 32'((k % 2) == 0));
`else
      kontrol("desen", 32'(vb_istek_hazir_o), 32'((k % 4) != 3));
`endif
      adim();
      @(posedge clk); #1;
    end

    repeat (8) dongu(0, 0, 100, 100, 100, 0);
    vb_istek_gecerli_i = 1'b0;

    // no responses: only DERIN requests fit, then one pop frees exactly one slot
    ib_kabul_say = 0;
    repeat (6) dongu(100, 0, 100, 0, 100, 0);
    kontrol("dolu_kabul", ib_kabul_say, DERIN);
    kontrol("dolu_blok", 32'({ib_istek_hazir_o, vb_istek_hazir_o}), 0);
    ib_kabul_say = 0;
    dongu(100, 0, 100, 100, 100, 0);
    repeat (4) dongu(100, 0, 100, 0, 100, 0);
    kontrol("tek_kabul", ib_kabul_say, 1);
    repeat (10) dongu(0, 0, 100, 100, 100, 0);

    repeat (800) dongu(60, 40, 70, 60, 75, 6);

    ib_istek_gecerli_i = 1'b1; bel_istek_hazir_i = 1'b1;
    bel_yanit_gecerli_i = 1'b1; bel_yanit_veri_i = 32'h1234_5678;
    rst = 1'b1;
    #1;
    sifir_kontrol("orta_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_sifirla();

    repeat (800) dongu(60, 40, 70, 60, 75, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
